// File: rtl/dds_osc_pkg.sv
// Shared definitions for the recursive sine oscillator sequencer: state encoding,
// ROM word offsets and datapath widths.
package dds_osc_pkg;

    localparam int COEF_W = 32;
    localparam int MODE_W = 3;

    localparam logic ROM_SIN_OFS = 1'b0;
    localparam logic ROM_COS_OFS = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH0  = 4'd1,
        S_FETCH1  = 4'd2,
        S_FETCH2  = 4'd3,
        S_LOAD    = 4'd4,
        S_RUN     = 4'd5,
        S_RFETCH0 = 4'd6,
        S_RFETCH1 = 4'd7,
        S_RFETCH2 = 4'd8,
        S_RCOMMIT = 4'd9
    } seq_state_t;

    // States in which the oscillator is live and the sample tick keeps running
    function automatic logic is_run_state(input seq_state_t s);
        return (s == S_RUN) || (s == S_RFETCH0) || (s == S_RFETCH1) ||
               (s == S_RFETCH2) || (s == S_RCOMMIT);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: emits a registered 1-cycle tick every SAMPLE_DIV cycles while run is high.
// The load/run inputs describe the coming cycle, so the tick lands exactly on the divider boundary.
module sample_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] count_r;

    // Down-counter with reload at zero; the tick is registered alongside the reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tick    <= 1'b0;
        end else if (load) begin
            count_r <= RELOAD;
            tick    <= 1'b0;
        end else if (run) begin
            if (count_r == '0) begin
                count_r <= RELOAD;
                tick    <= 1'b1;
            end else begin
                count_r <= count_r - DIV_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/osc_sequencer.sv
// Oscillator sequencer: fetches the (sin, 2cos) coefficient pair from ROM, loads or retunes
// the oscillator, and drives the sample tick. All strobes are registered from the next state.
module osc_sequencer
    import dds_osc_pkg::*;
#(
    parameter int IDX_W      = 8,
    parameter int DIV_W      = 16,
    parameter int SAMPLE_DIV = 100,
    parameter int MIN_GAP    = 2
) (
    input  logic              Fg_CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Cfg_Valid,
    output logic              Cfg_Ready,
    input  logic [IDX_W-1:0]  Cfg_FreqIdx,
    input  logic [MODE_W-1:0] Cfg_Mode,
    output logic              Rom_Rd,
    output logic [IDX_W:0]    Rom_Addr,
    input  logic [COEF_W-1:0] Rom_Data,
    output logic              Osc_Ready,
    output logic              Osc_Enable,
    output logic              Osc_FreqChng,
    output logic [MODE_W-1:0] Osc_Mode,
    output logic [COEF_W-1:0] Osc_Sinx,
    output logic [COEF_W-1:0] Osc_Cos2x,
    output logic              Running
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);

    seq_state_t        state_r;
    seq_state_t        next_state_s;
    logic [IDX_W-1:0]  cfg_idx_r;
    logic [MODE_W-1:0] cfg_mode_r;
    logic [COEF_W-1:0] stage_sin_r;
    logic [GAP_W-1:0]  gap_r;
    logic              accept_s;
    logic [IDX_W-1:0]  fetch_idx_s;
    logic              rom_rd_s;
    logic [IDX_W:0]    rom_addr_s;
    logic              commit_s;

    // Stop masks acceptance in the same cycle, so no config slips in while halting
    assign Cfg_Ready = ~RESET & ~Stop &
                       ((state_r == S_IDLE) | ((state_r == S_RUN) & (gap_r == '0)));
    assign accept_s    = Cfg_Valid & Cfg_Ready;
    assign fetch_idx_s = accept_s ? Cfg_FreqIdx : cfg_idx_r;
    assign commit_s    = (next_state_s == S_LOAD) | (next_state_s == S_RCOMMIT);

    // Next-state decode; Stop has priority over every other request
    always_comb begin
        next_state_s = state_r;
        if (Stop) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:    next_state_s = Start ? S_FETCH0 : S_IDLE;
                S_FETCH0:  next_state_s = S_FETCH1;
                S_FETCH1:  next_state_s = S_FETCH2;
                S_FETCH2:  next_state_s = S_LOAD;
                S_LOAD:    next_state_s = S_RUN;
                S_RUN:     next_state_s = accept_s ? S_RFETCH0 : S_RUN;
                S_RFETCH0: next_state_s = S_RFETCH1;
                S_RFETCH1: next_state_s = S_RFETCH2;
                S_RFETCH2: next_state_s = S_RCOMMIT;
                S_RCOMMIT: next_state_s = S_RUN;
                default:   next_state_s = S_IDLE;
            endcase
        end
    end

    // ROM request for the coming cycle; the sin word uses a freshly accepted index directly
    always_comb begin
        rom_rd_s   = 1'b0;
        rom_addr_s = '0;
        case (next_state_s)
            S_FETCH0, S_RFETCH0: begin
                rom_rd_s   = 1'b1;
                rom_addr_s = {fetch_idx_s, ROM_SIN_OFS};
            end
            S_FETCH1, S_RFETCH1: begin
                rom_rd_s   = 1'b1;
                rom_addr_s = {cfg_idx_r, ROM_COS_OFS};
            end
            default: begin
                rom_rd_s   = 1'b0;
                rom_addr_s = '0;
            end
        endcase
    end

    // State, stored config, staging and registered oscillator-side outputs
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= S_IDLE;
            cfg_idx_r    <= '0;
            cfg_mode_r   <= '0;
            stage_sin_r  <= '0;
            gap_r        <= '0;
            Rom_Rd       <= 1'b0;
            Rom_Addr     <= '0;
            Osc_Ready    <= 1'b0;
            Osc_FreqChng <= 1'b0;
            Osc_Mode     <= '0;
            Osc_Sinx     <= '0;
            Osc_Cos2x    <= '0;
            Running      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cfg_idx_r  <= Cfg_FreqIdx;
                cfg_mode_r <= Cfg_Mode;
            end
            Rom_Rd <= rom_rd_s;
            if (rom_rd_s) begin
                Rom_Addr <= rom_addr_s;
            end
            if ((state_r == S_FETCH1) || (state_r == S_RFETCH1)) begin
                stage_sin_r <= Rom_Data;
            end
            // The 2cos word is on Rom_Data in the last fetch cycle, so it commits straight through
            if (commit_s) begin
                Osc_Sinx  <= stage_sin_r;
                Osc_Cos2x <= Rom_Data;
                Osc_Mode  <= cfg_mode_r;
            end
            Osc_Ready    <= (next_state_s == S_LOAD);
            Osc_FreqChng <= (next_state_s == S_RCOMMIT);
            Running      <= is_run_state(next_state_s);
            if (next_state_s == S_RCOMMIT) begin
                gap_r <= GAP_W'(MIN_GAP);
            end else if (next_state_s == S_LOAD) begin
                gap_r <= '0;
            end else if (Osc_Enable && (gap_r != '0)) begin
                gap_r <= gap_r - GAP_W'(1);
            end
        end
    end

    sample_tick_gen #(
        .DIV_W      (DIV_W),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (Fg_CLK),
        .rst  (RESET),
        .load (next_state_s == S_LOAD),
        .run  (is_run_state(next_state_s)),
        .tick (Osc_Enable)
    );

endmodule

// File: tb/tb_osc_sequencer.sv
// Scoreboard bench for osc_sequencer: directed stimulus pushes expected ROM reads and
// load/retune strobes; a negedge monitor pops and compares them and checks the tick cadence.
module tb_osc_sequencer;

    localparam int DIV = 4;
    localparam int GAP = 2;
    localparam int K_ROM = 0;
    localparam int K_READY = 1;
    localparam int K_FREQ = 2;

    logic        Fg_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic        Cfg_Valid = 1'b0;
    logic        Cfg_Ready;
    logic [7:0]  Cfg_FreqIdx = 8'd0;
    logic [2:0]  Cfg_Mode = 3'd0;
    logic        Rom_Rd;
    logic [8:0]  Rom_Addr;
    logic [31:0] Rom_Data = 32'd0;
    logic        Osc_Ready;
    logic        Osc_Enable;
    logic        Osc_FreqChng;
    logic [2:0]  Osc_Mode;
    logic [31:0] Osc_Sinx;
    logic [31:0] Osc_Cos2x;
    logic        Running;

    typedef struct {
        int          kind;
        logic [8:0]  addr;
        logic [31:0] sinx;
        logic [31:0] cos2x;
        logic [2:0]  mode;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;
    int  last_mark = -1;

    osc_sequencer #(
        .IDX_W(8), .DIV_W(16), .SAMPLE_DIV(DIV), .MIN_GAP(GAP)
    ) dut (
        .Fg_CLK(Fg_CLK), .RESET(RESET), .Start(Start), .Stop(Stop),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready), .Cfg_FreqIdx(Cfg_FreqIdx),
        .Cfg_Mode(Cfg_Mode), .Rom_Rd(Rom_Rd), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
        .Osc_Ready(Osc_Ready), .Osc_Enable(Osc_Enable), .Osc_FreqChng(Osc_FreqChng),
        .Osc_Mode(Osc_Mode), .Osc_Sinx(Osc_Sinx), .Osc_Cos2x(Osc_Cos2x), .Running(Running)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    // Coefficient ROM: sin word 0x1000_00ii, 2cos word 0x4000_00ii, one cycle latency
    always @(posedge Fg_CLK) begin
        if (Rom_Rd) begin
            Rom_Data <= (Rom_Addr[0] ? 32'h4000_0000 : 32'h1000_0000) | {24'd0, Rom_Addr[8:1]};
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void expect_rom(input logic [8:0] addr);
        ev_t e;
        e.kind = K_ROM; e.addr = addr; e.sinx = 32'd0; e.cos2x = 32'd0; e.mode = 3'd0;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_coef(input int kind, input logic [31:0] s,
                                        input logic [31:0] c, input logic [2:0] m);
        ev_t e;
        e.kind = kind; e.addr = 9'd0; e.sinx = s; e.cos2x = c; e.mode = m;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input int kind);
        ev_t e;
        check("event_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_ROM) begin
                check("rom_addr", Rom_Addr, e.addr);
            end else begin
                check("osc_sinx", Osc_Sinx, e.sinx);
                check("osc_cos2x", Osc_Cos2x, e.cos2x);
                check("osc_mode", Osc_Mode, e.mode);
            end
        end
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks the sample-tick cadence
    always @(negedge Fg_CLK) begin
        cyc++;
        if (Rom_Rd) observe(K_ROM);
        if (Osc_Ready) observe(K_READY);
        if (Osc_FreqChng) observe(K_FREQ);
        if (Osc_Enable) begin
            check("enable_not_with_ready", Osc_Ready, 1'b0);
            check("enable_in_run", last_mark >= 0, 1'b1);
            if (last_mark >= 0) check("enable_spacing", cyc - last_mark, DIV);
            last_mark = cyc;
        end
        if (Osc_Ready) last_mark = cyc;
        else if (!Running) last_mark = -1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Fg_CLK);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] idx, input logic [2:0] mode);
        int n;
        n = 0;
        while (!Cfg_Ready && n < 50) begin
            step(1);
            n++;
        end
        check("cfg_ready_wait", Cfg_Ready, 1'b1);
        Cfg_Valid = 1'b1; Cfg_FreqIdx = idx; Cfg_Mode = mode;
        step(1);
        Cfg_Valid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step(1);
        Start = 1'b0;
    endtask

    task automatic wait_strobe(input int kind, input string name);
        int  n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge Fg_CLK);
            seen = (kind == K_READY) ? Osc_Ready : Osc_FreqChng;
            n++;
        end
        check(name, seen, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int ticks;
        int n;
        // Reset state
        #2;
        check("rst_running", Running, 1'b0);
        check("rst_cfg_ready", Cfg_Ready, 1'b0);
        check("rst_rom_rd", Rom_Rd, 1'b0);
        check("rst_sinx", Osc_Sinx, 32'd0);
        #10 RESET = 1'b0;
        step(1);
        check("idle_cfg_ready", Cfg_Ready, 1'b1);
        check("idle_running", Running, 1'b0);

        // Initial load: idx 5, mode 1
        expect_rom(9'd10); expect_rom(9'd11);
        expect_coef(K_READY, 32'h1000_0005, 32'h4000_0005, 3'd1);
        send_cfg(8'd5, 3'd1);
        pulse_start();
        wait_strobe(K_READY, "load_ready_seen");
        step(14);
        check("run_running", Running, 1'b1);

        // Retune to idx 7, mode 2 with the gap window afterwards
        expect_rom(9'd14); expect_rom(9'd15);
        expect_coef(K_FREQ, 32'h1000_0007, 32'h4000_0007, 3'd2);
        send_cfg(8'd7, 3'd2);
        wait_strobe(K_FREQ, "retune_seen");
        ticks = 0; n = 0;
        while (ticks < GAP && n < 40) begin
            check("gap_ready_low", Cfg_Ready, 1'b0);
            if (Osc_Enable) ticks++;
            if (ticks < GAP) @(negedge Fg_CLK);
            n++;
        end
        @(negedge Fg_CLK);
        check("gap_ready_release", Cfg_Ready, 1'b1);
        step(6);

        // Stop in RFETCH1: both reads happen, no commit
        expect_rom(9'h040); expect_rom(9'h041);
        send_cfg(8'h20, 3'd3);
        step(1);
        Stop = 1'b1;
        step(1);
        Stop = 1'b0;
        check("stop_running", Running, 1'b0);
        step(5);
        check("stop_sinx_held", Osc_Sinx, 32'h1000_0007);
        check("stop_cos2x_held", Osc_Cos2x, 32'h4000_0007);
        check("stop_mode_held", Osc_Mode, 3'd2);

        // Restart with the stored idx 0x20, then Stop+Start together
        expect_rom(9'h040); expect_rom(9'h041);
        expect_coef(K_READY, 32'h1000_0020, 32'h4000_0020, 3'd3);
        pulse_start();
        wait_strobe(K_READY, "restart_ready_seen");
        step(7);
        Stop = 1'b1; Start = 1'b1;
        step(1);
        Stop = 1'b0; Start = 1'b0;
        check("stopstart_running", Running, 1'b0);
        step(3);
        check("stopstart_idle", Cfg_Ready, 1'b1);
        check("stopstart_rom_rd", Rom_Rd, 1'b0);

        // Two configs in IDLE: only the last one is fetched
        expect_rom(9'd18); expect_rom(9'd19);
        expect_coef(K_READY, 32'h1000_0009, 32'h4000_0009, 3'd5);
        send_cfg(8'd3, 3'd4);
        send_cfg(8'd9, 3'd5);
        pulse_start();
        wait_strobe(K_READY, "lastwins_ready_seen");
        step(6);

        // Asynchronous reset between edges while running
        #2 RESET = 1'b1;
        #1;
        check("arst_running", Running, 1'b0);
        check("arst_cfg_ready", Cfg_Ready, 1'b0);
        check("arst_enable", Osc_Enable, 1'b0);
        check("arst_rom_addr", Rom_Addr, 9'd0);
        check("arst_sinx", Osc_Sinx, 32'd0);
        check("arst_cos2x", Osc_Cos2x, 32'd0);
        check("arst_mode", Osc_Mode, 3'd0);
        repeat (2) @(posedge Fg_CLK);
        #3 RESET = 1'b0;
        step(1);
        check("post_rst_idle", Cfg_Ready, 1'b1);
        check("post_rst_running", Running, 1'b0);
        step(4);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
